// File: rtl/delay_line_ctrl.sv
// Sequencer for a shift-register delay-line bank: derives clock_ena/sclr strobes from an
// upstream valid/ready stream and a downstream ready, and tracks real-sample occupancy.
module delay_line_ctrl #(
    parameter int unsigned DELAY = 300,
    parameter int unsigned CNT_W = 9
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             flush_req,
    input  logic             drain_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             line_ena,
    output logic             line_sclr,
    output logic [CNT_W-1:0] fill_cnt,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StRun   = 3'd2,
        StPad   = 3'd3,
        StDrain = 3'd4,
        StFlush = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] DelayC = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] OneC   = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0] r_shift_cnt;
    logic [CNT_W-1:0] w_fill_nxt;
    logic [CNT_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_fill_inc;
    logic [CNT_W-1:0] w_shift_inc;
    logic             w_accept;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state     <= StIdle;
            r_fill_cnt  <= '0;
            r_shift_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_shift_cnt <= w_shift_nxt;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        line_ena  = 1'b0;
        out_valid = 1'b0;
        line_sclr = 1'b0;
        unique case (r_state)
            StIdle, StFill: begin
                in_ready = 1'b1;
                line_ena = in_valid;
            end
            // A shift in RUN both consumes and accepts, so occupancy stays full.
            StRun: begin
                in_ready  = out_ready;
                line_ena  = in_valid && out_ready;
                out_valid = 1'b1;
            end
            StPad: begin
                line_ena = 1'b1;
            end
            StDrain: begin
                line_ena  = out_ready;
                out_valid = 1'b1;
            end
            StFlush: begin
                line_sclr = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_accept    = in_valid && in_ready;
    assign w_fill_inc  = r_fill_cnt + OneC;
    assign w_shift_inc = r_shift_cnt + OneC;

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_shift_nxt = r_shift_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_fill_nxt  = OneC;
                    w_shift_nxt = OneC;
                    w_state_nxt = (DELAY == 1) ? StRun : StFill;
                end
            end
            StFill: begin
                if (w_accept) begin
                    w_fill_nxt  = w_fill_inc;
                    w_shift_nxt = w_shift_inc;
                    if (w_fill_inc == DelayC) begin
                        w_state_nxt = drain_req ? StDrain : StRun;
                    end else if (drain_req) begin
                        w_state_nxt = StPad;
                    end
                end else if (drain_req) begin
                    w_state_nxt = StPad;
                end
            end
            StRun: begin
                if (drain_req) begin
                    w_state_nxt = StDrain;
                end
            end
            // Zeros are pushed in until the oldest real sample reaches sig_out.
            StPad: begin
                w_shift_nxt = w_shift_inc;
                if (w_shift_inc == DelayC) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (out_ready && (r_fill_cnt != '0)) begin
                    w_fill_nxt = r_fill_cnt - OneC;
                    if (r_fill_cnt == OneC) begin
                        w_shift_nxt = '0;
                        w_state_nxt = StIdle;
                    end
                end
            end
            StFlush: begin
                w_fill_nxt  = '0;
                w_shift_nxt = '0;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        if (flush_req && (r_state != StFlush)) begin
            w_state_nxt = StFlush;
        end
    end

    assign fill_cnt = r_fill_cnt;
    assign state    = r_state;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: a DELAY=4 and a DELAY=1 instance share stimulus; a line-occupancy
// model checks both every cycle, and directed literal checks pin the expected sequences.
module tb_delay_line_ctrl;

    logic clock;
    logic aclr;
    logic flush_req;
    logic drain_req;
    logic in_valid;
    logic out_ready;

    logic       d_ir   [2];
    logic       d_ov   [2];
    logic       d_ena  [2];
    logic       d_sclr [2];
    logic [2:0] d_state[2];
    logic [2:0] d_fill4;
    logic [1:0] d_fill1;

    int n_pass;
    int n_total;

    // Model: per instance, the real/empty flag of every line stage plus the current phase.
    bit mline [2][4];
    int mphase[2];

    delay_line_ctrl #(.DELAY(4), .CNT_W(3)) u_dut4 (
        .clock     (clock),
        .aclr      (aclr),
        .flush_req (flush_req),
        .drain_req (drain_req),
        .in_valid  (in_valid),
        .in_ready  (d_ir[0]),
        .out_ready (out_ready),
        .out_valid (d_ov[0]),
        .line_ena  (d_ena[0]),
        .line_sclr (d_sclr[0]),
        .fill_cnt  (d_fill4),
        .state     (d_state[0])
    );

    delay_line_ctrl #(.DELAY(1), .CNT_W(2)) u_dut1 (
        .clock     (clock),
        .aclr      (aclr),
        .flush_req (flush_req),
        .drain_req (drain_req),
        .in_valid  (in_valid),
        .in_ready  (d_ir[1]),
        .out_ready (out_ready),
        .out_valid (d_ov[1]),
        .line_ena  (d_ena[1]),
        .line_sclr (d_sclr[1]),
        .fill_cnt  (d_fill1),
        .state     (d_state[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic model_cycle(input int k);
        int d, cnt, act_fill, nph;
        bit e_ir, e_ov, e_ena, e_sclr, acc;
        d = (k == 0) ? 4 : 1;
        if (aclr) begin
            mphase[k] = 0;
            for (int i = 0; i < 4; i++) mline[k][i] = 1'b0;
        end
        cnt = 0;
        for (int i = 0; i < d; i++) cnt += int'(mline[k][i]);
        e_ir = 0; e_ov = 0; e_ena = 0; e_sclr = 0;
        case (mphase[k])
            0, 1: begin e_ir = 1; e_ena = in_valid; end
            2: begin e_ir = out_ready; e_ena = in_valid && out_ready; e_ov = 1; end
            3: e_ena = 1;
            4: begin e_ena = out_ready; e_ov = 1; end
            5: e_sclr = 1;
            default: ;
        endcase
        act_fill = (k == 0) ? int'(d_fill4) : int'(d_fill1);
        n_total++;
        if (int'(d_state[k]) == mphase[k] && d_ir[k] == e_ir && d_ov[k] == e_ov &&
            d_ena[k] == e_ena && d_sclr[k] == e_sclr && act_fill == cnt) begin
            n_pass++;
        end else begin
            $display("FAIL cycle u%0d t=%0t: got st=%0d ir=%0b ov=%0b ena=%0b sclr=%0b fill=%0d, want st=%0d ir=%0b ov=%0b ena=%0b sclr=%0b fill=%0d",
                     k, $time, d_state[k], d_ir[k], d_ov[k], d_ena[k], d_sclr[k], act_fill,
                     mphase[k], e_ir, e_ov, e_ena, e_sclr, cnt);
        end
        if (!aclr) begin
            acc = e_ir && in_valid;
            if (e_ena) begin
                for (int i = d - 1; i > 0; i--) mline[k][i] = mline[k][i-1];
                mline[k][0] = acc;
            end
            cnt = 0;
            for (int i = 0; i < d; i++) cnt += int'(mline[k][i]);
            nph = mphase[k];
            case (mphase[k])
                0: if (acc) nph = (d == 1) ? 2 : 1;
                1: begin
                    if (cnt == d) nph = drain_req ? 4 : 2;
                    else if (drain_req) nph = 3;
                end
                2: if (drain_req) nph = 4;
                3: if (mline[k][d-1]) nph = 4;
                4: if (cnt == 0) nph = 0;
                5: begin
                    for (int i = 0; i < 4; i++) mline[k][i] = 1'b0;
                    nph = 0;
                end
                default: nph = 0;
            endcase
            if (flush_req && mphase[k] != 5) nph = 5;
            mphase[k] = nph;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clock);
            model_cycle(0);
            model_cycle(1);
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        aclr = 1'b1;
        flush_req = 1'b0;
        drain_req = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        fork
            compare_loop();
        join_none
        step();
        step();
        aclr = 1'b0;
        #1;
        chk("reset_state", int'(d_state[0]), 0);
        chk("reset_fill", int'(d_fill4), 0);
        chk("reset_ov", int'(d_ov[0]), 0);
        chk("reset_ir", int'(d_ir[0]), 1);

        // Prime with four back-to-back samples.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("prime_state", int'(d_state[0]), (i == 0) ? 0 : 1);
            chk("prime_fill", int'(d_fill4), i);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("run_state", int'(d_state[0]), 2);
        chk("run_ov", int'(d_ov[0]), 1);
        chk("run_fill", int'(d_fill4), 4);

        // Steady state with out_ready toggling.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_ready = (i % 2 == 0);
            #1;
            chk("run_ena", int'(d_ena[0]), int'(out_ready));
            chk("run_ir", int'(d_ir[0]), int'(out_ready));
            step();
        end
        #1;
        chk("run_fill_hold", int'(d_fill4), 4);

        // Drain from RUN with the consumer stalled for three cycles.
        drain_req = 1'b1;
        out_ready = 1'b0;
        step();
        drain_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_stall_state", int'(d_state[0]), 4);
            chk("drain_stall_fill", int'(d_fill4), 4);
            chk("drain_stall_ir", int'(d_ir[0]), 0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_fill", int'(d_fill4), 4 - i);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("drain_done_state", int'(d_state[0]), 0);
        chk("drain_done_fill", int'(d_fill4), 0);

        // Partial fill then drain: two PAD cycles.
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        drain_req = 1'b1;
        #1;
        chk("pfill_state", int'(d_state[0]), 1);
        chk("pfill_fill", int'(d_fill4), 2);
        step();
        drain_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("pad_state", int'(d_state[0]), 3);
            chk("pad_ena", int'(d_ena[0]), 1);
            chk("pad_ir", int'(d_ir[0]), 0);
            chk("pad_ov", int'(d_ov[0]), 0);
            step();
        end
        #1;
        chk("pad_to_drain", int'(d_state[0]), 4);
        chk("pad_drain_fill", int'(d_fill4), 2);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        #1;
        chk("pad_done_state", int'(d_state[0]), 0);
        chk("pad_done_fill", int'(d_fill4), 0);

        // Flush during PAD.
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        flush_req = 1'b1;
        #1;
        chk("flush_from_pad", int'(d_state[0]), 3);
        step();
        flush_req = 1'b0;
        #1;
        chk("flush_state", int'(d_state[0]), 5);
        chk("flush_sclr", int'(d_sclr[0]), 1);
        chk("flush_ena", int'(d_ena[0]), 0);
        step();
        #1;
        chk("flush_done_state", int'(d_state[0]), 0);
        chk("flush_done_fill", int'(d_fill4), 0);
        chk("flush_done_ov", int'(d_ov[0]), 0);

        // Held flush alternates FLUSH and IDLE.
        flush_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("flush_hold_state", int'(d_state[0]), (i % 2 == 0) ? 0 : 5);
            step();
        end
        flush_req = 1'b0;
        step();

        // Drain arriving with the final fill accept goes straight to DRAIN.
        in_valid = 1'b1;
        step();
        step();
        step();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fill_drain_state", int'(d_state[0]), 4);
        chk("fill_drain_fill", int'(d_fill4), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        #1;
        chk("fill_drain_done", int'(d_state[0]), 0);

        // DELAY=1 goes IDLE -> RUN; aclr mid-RUN returns it to IDLE at once.
        aclr = 1'b1;
        step();
        aclr = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("d1_run_state", int'(d_state[1]), 2);
        chk("d1_run_ov", int'(d_ov[1]), 1);
        chk("d1_run_fill", int'(d_fill1), 1);
        chk("d4_fill_state", int'(d_state[0]), 1);
        aclr = 1'b1;
        #1;
        chk("d1_aclr_state", int'(d_state[1]), 0);
        chk("d1_aclr_ov", int'(d_ov[1]), 0);
        chk("d1_aclr_fill", int'(d_fill1), 0);
        chk("d1_aclr_ir", int'(d_ir[1]), 1);
        chk("d1_aclr_ena", int'(d_ena[1]), 0);
        step();
        aclr = 1'b0;
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequencer for a shift-register delay-line bank: a DELAY-stage line with shared sclr and clock_ena.
- Turns an upstream valid/ready stream and a downstream ready into the line's clock_ena and sclr strobes.
- Tracks how many real samples are in the line and flags when the line output holds a real sample.
- Supports prime (fill), steady-state run, drain (pads with zeros until the last real sample exits) and synchronous flush.

Parameters:
- DELAY, 300, number of stages in the controlled line; legal range DELAY >= 1.
- CNT_W, 9, width of the occupancy and shift counters; must satisfy 2**CNT_W > DELAY.

Ports:
- clock  in  1  system clock, rising edge.
- aclr  in  1  asynchronous active-high reset; also wired to the controlled line's aclr.
- flush_req  in  1  synchronous flush request, level-sampled.
- drain_req  in  1  drain request, level-sampled.
- in_valid  in  1  upstream sample present on the line's sig_in.
- in_ready  out  1  controller accepts the upstream sample this cycle.
- out_ready  in  1  downstream consumes the line's sig_out this cycle.
- out_valid  out  1  line's sig_out currently holds a real sample.
- line_ena  out  1  drives the line's clock_ena; one shift per asserted cycle.
- line_sclr  out  1  drives the line's sclr.
- fill_cnt  out  CNT_W  number of real samples currently in the line.
- state  out  3  IDLE=0, FILL=1, RUN=2, PAD=3, DRAIN=4, FLUSH=5.

Behaviour:
Reset and registered state:
- aclr forces state=IDLE, fill_cnt=0, shift_cnt=0.
- Registers: state, fill_cnt, shift_cnt. shift_cnt counts shifts since the oldest real sample entered, saturating at DELAY.
- Oldest real sample is at sig_out exactly when shift_cnt==DELAY.
- Every shift is exactly one line_ena cycle. Real samples always sit contiguously in the line.

Combinational outputs per state (no registered output latency):
- IDLE, FILL: in_ready=1, line_ena=in_valid, out_valid=0.
- RUN: in_ready=out_ready, line_ena=in_valid&&out_ready, out_valid=1.
  - A consume happens only with a simultaneous accept, so fill_cnt stays DELAY.
- PAD: in_ready=0, line_ena=1 (shifts zeros in), out_valid=0.
- DRAIN: in_ready=0, line_ena=out_ready, out_valid=1.
- FLUSH: in_ready=0, line_ena=0, out_valid=0, line_sclr=1.
- line_sclr=0 in every state except FLUSH.

Transitions (flush_req has highest priority from any state except FLUSH; FLUSH lasts exactly 1 cycle):
- flush_req=1 -> FLUSH; the next cycle clears fill_cnt and shift_cnt and goes to IDLE.
- flush_req held high re-enters FLUSH each alternate cycle; the line stays cleared.
- IDLE: accepted sample -> fill_cnt=1, shift_cnt=1. Then RUN if DELAY==1, otherwise FILL.
  - drain_req in IDLE is ignored.
- FILL: each accept increments fill_cnt and shift_cnt; on reaching DELAY -> RUN.
  - drain_req=1 with no final-fill accept -> PAD. The accept counts if it happens the same cycle.
  - If that accept reaches DELAY -> DRAIN directly.
- RUN: drain_req=1 -> DRAIN after this cycle's transfer (if any) completes.
- PAD: shift_cnt increments each cycle; fill_cnt is unchanged.
  - When shift_cnt reaches DELAY -> DRAIN. Takes DELAY-fill_cnt cycles.
- DRAIN: each out_ready cycle decrements fill_cnt; the cycle it becomes 0 -> IDLE with shift_cnt=0.
  - drain_req is ignored once in PAD/DRAIN.

Boundary conditions:
- Counters never exceed DELAY; fill_cnt never underflows.
- out_valid=1 guarantees real data at sig_out.
- aclr mid-operation returns to IDLE immediately; the line is cleared by the same aclr.

Test Plan:
- DELAY=4, reset, 4 back-to-back in_valid samples -> state FILL, FILL, FILL then RUN; out_valid rises on the cycle after the 4th accept; fill_cnt=4.
- RUN with in_valid=1, out_ready toggling 1/0 -> line_ena and in_ready follow out_ready exactly; outputs equal inputs delayed by 4 transfers; fill_cnt holds 4.
- DELAY=4, accept 2 samples then drain_req -> PAD for exactly 2 cycles (line_ena=1, in_ready=0); then DRAIN emits 2 samples; then IDLE with fill_cnt=0.
- RUN, drain_req with out_ready stalled 3 cycles -> DRAIN holds fill_cnt=4 while stalled; 4 consumes then IDLE; no accepts occur.
- flush_req asserted in PAD -> one cycle FLUSH with line_sclr=1, line_ena=0; then IDLE, fill_cnt=0, out_valid=0.
- DELAY=1, single accept -> IDLE goes directly to RUN; aclr asserted mid-RUN -> IDLE immediately, all outputs at reset values.
